// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Groups the requester-side and memory-side signals of the shared memory port
// arbiter so the arbiter and its environment connect through one bundle.
//
// Parameters
//   ADDR_W     width of every address field
//   LEN_W      width of every burst-length field
// Signals
//   req        [2:0]          per-requester burst request
//   req_addr   [3*ADDR_W-1:0] per-requester burst base address (slice i)
//   req_len    [3*LEN_W-1:0]  per-requester burst length in beats (slice i)
//   gnt        [2:0]          one-hot grant, held for the whole burst
//   mem_en                    beat valid towards the shared memory
//   mem_addr   [ADDR_W-1:0]   beat address
//   mem_ready                 memory accepts the beat when high with mem_en
//   burst_done [2:0]          one-cycle pulse on the owner's bit at last beat
//   busy                      high while a grant or burst is in progress
// Modports
//   master     environment side (drives requests and mem_ready)
//   slave      arbiter side
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 10
);
    logic [2:0]          req;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*LEN_W-1:0]  req_len;
    logic [2:0]          gnt;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ready;
    logic [2:0]          burst_done;
    logic                busy;

    modport master (
        output req, req_addr, req_len, mem_ready,
        input  gnt, mem_en, mem_addr, burst_done, busy
    );

    modport slave (
        input  req, req_addr, req_len, mem_ready,
        output gnt, mem_en, mem_addr, burst_done, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between three layer engines. An idle arbiter picks
// one requester, latches its base address and burst length, spends one GRANT
// cycle announcing the grant, then streams beats (base + beat index, wrapping
// modulo 2^ADDR_W) until the last beat is accepted, and returns to IDLE.
//
// Parameters
//   ADDR_W     address width
//   LEN_W      burst-length width (a length of 0 is run as a single beat)
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        mem_port_arbiter_if.slave (see interface file for the signals)
// Build option
//   ARB_FIXED_PRIO_EN  when defined, fixed priority 0 > 1 > 2 replaces the
//                      round-robin search and the round-robin pointer is gone.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arbState_e;

    arbState_e          r_state;
    arbState_e          w_nextState;

    logic [2:0]         r_gnt;
    logic [ADDR_W-1:0]  r_base;
    logic [LEN_W-1:0]   r_lastBeat;
    logic [LEN_W-1:0]   r_beat;

    logic [1:0]         w_winIdx;
    logic [2:0]         w_winOneHot;
    logic [LEN_W-1:0]   w_winLen;
    logic [ADDR_W-1:0]  w_winAddr;
    logic               w_accept;
    logic               w_lastAccept;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: lowest index wins. Only meaningful when req != 0.
    always_comb begin
        if (bus.req[0]) begin
            w_winIdx = 2'd0;
        end else if (bus.req[1]) begin
            w_winIdx = 2'd1;
        end else begin
            w_winIdx = 2'd2;
        end
    end
`else
    // Index of the most recently granted requester; reset to 2 so the first
    // search starts at requester 0.
    logic [1:0] r_lastIdx;

    // Round-robin: search starts just after the last winner and wraps 2->0.
    // The final fallback of each search is the last winner itself, which is
    // the only candidate left once the other two were found idle.
    always_comb begin
        case (r_lastIdx)
            2'd0: begin
                if (bus.req[1])      w_winIdx = 2'd1;
                else if (bus.req[2]) w_winIdx = 2'd2;
                else                 w_winIdx = 2'd0;
            end
            2'd1: begin
                if (bus.req[2])      w_winIdx = 2'd2;
                else if (bus.req[0]) w_winIdx = 2'd0;
                else                 w_winIdx = 2'd1;
            end
            default: begin
                if (bus.req[0])      w_winIdx = 2'd0;
                else if (bus.req[1]) w_winIdx = 2'd1;
                else                 w_winIdx = 2'd2;
            end
        endcase
    end

    // Pointer follows every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastIdx <= 2'd2;
        end else if (r_state == IDLE && bus.req != 3'b000) begin
            r_lastIdx <= w_winIdx;
        end
    end
`endif

    assign w_winOneHot = 3'b001 << w_winIdx;
    assign w_winAddr   = bus.req_addr[int'(w_winIdx)*ADDR_W +: ADDR_W];
    assign w_winLen    = bus.req_len[int'(w_winIdx)*LEN_W +: LEN_W];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and all outputs. Outputs derive only from registered state
    // and mem_ready, so reset clears them without waiting for a clock edge.
    always_comb begin
        w_nextState    = r_state;
        w_accept       = 1'b0;
        w_lastAccept   = 1'b0;
        bus.gnt        = r_gnt;
        bus.mem_en     = 1'b0;
        bus.mem_addr   = '0;
        bus.burst_done = 3'b000;
        bus.busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req != 3'b000) begin
                    w_nextState = GRANT;
                end
            end
            GRANT: begin
                bus.busy    = 1'b1;
                w_nextState = BURST;
            end
            BURST: begin
                bus.busy     = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = r_base + ADDR_W'(r_beat);
                w_accept     = bus.mem_ready;
                if (w_accept && r_beat == r_lastBeat) begin
                    w_lastAccept   = 1'b1;
                    bus.burst_done = r_gnt;
                    w_nextState    = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Burst context: latched once at grant so later changes on the request
    // lines cannot disturb a running burst. The last-beat index is stored
    // instead of the length, which also folds length 0 into a single beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= 3'b000;
            r_base     <= '0;
            r_lastBeat <= '0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req != 3'b000) begin
                        r_gnt      <= w_winOneHot;
                        r_base     <= w_winAddr;
                        r_lastBeat <= (w_winLen == '0) ? '0 : w_winLen - LEN_W'(1);
                        r_beat     <= '0;
                    end
                end
                BURST: begin
                    if (w_lastAccept) begin
                        r_gnt  <= 3'b000;
                        r_beat <= '0;
                    end else if (w_accept) begin
                        r_beat <= r_beat + LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
